sobel_magnitude: RTL and testbench

- Stage directly downstream of the 3x3 Sobel convolution stage.
- Consumes the signed gx/gy gradient stream and produces an unsigned WIDTH_P-bit edge magnitude plus a binary edge flag.
- Masks border pixels whose convolution window is invalid, and tags the stream with frame/line markers for the pixel sink.
- Uses a 2-stage stallable valid/ready pipeline.

---
 rtl/sobel_pkg.sv | 23 ++
 rtl/sobel_abs_sat.sv | 26 ++
 rtl/sobel_magnitude.sv | 158 +++++++++++++++
 tb/tb_sobel_magnitude.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types, limits and the shift-and-saturate helper for the Sobel magnitude stage.
package sobel_pkg;

  localparam int PIX_W = 8;

  typedef logic signed [2*PIX_W-1:0] grad_t;
  typedef logic        [PIX_W-1:0]   mag_t;

  localparam mag_t MAG_MAX = '1;

  // Shift the gradient sum right and clamp it to the largest value that fits in 'width' bits.
  // Operates on a 32-bit container so callers of any pixel width up to 15 bits can share it.
  function automatic logic [31:0] sat_shift(input logic [31:0] sum,
                                            input int unsigned shift,
                                            input int unsigned width);
    logic [31:0] s;
    logic [31:0] lim;
    s   = sum >> shift;
    lim = (32'd1 << width) - 32'd1;
    return (s > lim) ? lim : s;
  endfunction

endpackage

// File: rtl/sobel_abs_sat.sv
// Combinational absolute value of a signed gradient; the most-negative code clamps to the
// largest positive value so the result always fits in the same unsigned width.
module sobel_abs_sat #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] i_val,
  output logic        [W-1:0] o_abs
);

  logic         w_is_min;
  logic [W-1:0] w_neg;

  assign w_is_min = i_val[W-1] & ~(|i_val[W-2:0]);
  assign w_neg    = ~i_val + {{(W-1){1'b0}}, 1'b1};

  // Select magnitude: clamp the most-negative code, negate other negatives, pass positives.
  always_comb begin
    o_abs = i_val;
    if (w_is_min) begin
      o_abs = {1'b0, {(W-1){1'b1}}};
    end else if (i_val[W-1]) begin
      o_abs = w_neg;
    end
  end

endmodule

// File: rtl/sobel_magnitude.sv
// Sobel edge magnitude stage: |gx|+|gy| shifted and saturated, border masking, edge flag and
// frame/line markers, in a 2-stage stallable valid/ready pipeline.
module sobel_magnitude
  import sobel_pkg::*;
#(
  parameter int WIDTH_P  = PIX_W,
  parameter int DEPTH_P  = 16,
  parameter int HEIGHT_P = 16,
  parameter int SHIFT_P  = 2
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic signed [2*WIDTH_P-1:0] gx_i,
  input  logic signed [2*WIDTH_P-1:0] gy_i,
  input  logic                        clear_i,
  input  logic        [WIDTH_P-1:0]   thresh_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic        [WIDTH_P-1:0]   mag_o,
  output logic                        edge_o,
  output logic                        sof_o,
  output logic                        eol_o,
  output logic                        eof_o
);

  localparam int CW = (DEPTH_P  > 1) ? $clog2(DEPTH_P)  : 1;
  localparam int RW = (HEIGHT_P > 1) ? $clog2(HEIGHT_P) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(DEPTH_P - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT_P - 1);

  // Handshake
  logic w_advance;
  logic w_accept;

  // Position counters and the tag of the beat being accepted
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [CW-1:0] w_tag_col;
  logic [RW-1:0] w_tag_row;
  logic [CW-1:0] w_col_nxt;
  logic [RW-1:0] w_row_nxt;
  logic          w_border;

  // Stage 1
  logic                   r_v1;
  logic [2*WIDTH_P-1:0]   r_ax;
  logic [2*WIDTH_P-1:0]   r_ay;
  logic [CW-1:0]          r_col1;
  logic [RW-1:0]          r_row1;
  logic                   r_border1;
  logic [2*WIDTH_P-1:0]   w_ax;
  logic [2*WIDTH_P-1:0]   w_ay;

  // Stage 2
  logic                   r_valid2;
  logic [WIDTH_P-1:0]     r_mag;
  logic                   r_edge;
  logic                   r_sof;
  logic                   r_eol;
  logic                   r_eof;
  logic [2*WIDTH_P:0]     w_sum;
  logic [WIDTH_P-1:0]     w_sat;
  logic [WIDTH_P-1:0]     w_mag;
  logic                   w_edge;
  logic                   w_sof;
  logic                   w_eol;
  logic                   w_eof;

  assign w_advance = ~r_valid2 | ready_i;
  assign ready_o   = w_advance;
  assign w_accept  = valid_i & w_advance;

  // A clear coinciding with an accept tags that beat as the frame origin.
  assign w_tag_col = clear_i ? '0 : r_col;
  assign w_tag_row = clear_i ? '0 : r_row;

  assign w_col_nxt = (w_tag_col == COL_LAST) ? '0 : w_tag_col + CW'(1);
  assign w_row_nxt = (w_tag_col != COL_LAST) ? w_tag_row :
                     (w_tag_row == ROW_LAST) ? '0 : w_tag_row + RW'(1);

  // The window centred on (row-1, col-1) is incomplete or wraps a row for the first two rows/cols.
  assign w_border = (32'(w_tag_row) < 32'd2) | (32'(w_tag_col) < 32'd2);

  // Position counters advance on accept; a bare clear returns them to the origin.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
    end else if (clear_i) begin
      r_col <= '0;
      r_row <= '0;
    end
  end

  sobel_abs_sat #(.W(2*WIDTH_P)) u_abs_gx (.i_val(gx_i), .o_abs(w_ax));
  sobel_abs_sat #(.W(2*WIDTH_P)) u_abs_gy (.i_val(gy_i), .o_abs(w_ay));

  // Stage 1 register: absolute gradients plus position tag and border flag.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_v1      <= 1'b0;
      r_ax      <= '0;
      r_ay      <= '0;
      r_col1    <= '0;
      r_row1    <= '0;
      r_border1 <= 1'b0;
    end else if (w_advance) begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_ax      <= w_ax;
        r_ay      <= w_ay;
        r_col1    <= w_tag_col;
        r_row1    <= w_tag_row;
        r_border1 <= w_border;
      end
    end
  end

  assign w_sum  = {1'b0, r_ax} + {1'b0, r_ay};
  assign w_sat  = WIDTH_P'(sat_shift(32'(w_sum), 32'(SHIFT_P), 32'(WIDTH_P)));
  assign w_mag  = r_border1 ? '0 : w_sat;
  assign w_edge = ~r_border1 & (w_mag >= thresh_i);
  assign w_sof  = (r_row1 == '0) & (r_col1 == '0);
  assign w_eol  = (r_col1 == COL_LAST);
  assign w_eof  = (r_row1 == ROW_LAST) & (r_col1 == COL_LAST);

  // Stage 2 register: magnitude, edge flag and markers; bubbles leave all outputs low.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_valid2 <= 1'b0;
      r_mag    <= '0;
      r_edge   <= 1'b0;
      r_sof    <= 1'b0;
      r_eol    <= 1'b0;
      r_eof    <= 1'b0;
    end else if (w_advance) begin
      r_valid2 <= r_v1;
      r_mag    <= r_v1 ? w_mag : '0;
      r_edge   <= r_v1 & w_edge;
      r_sof    <= r_v1 & w_sof;
      r_eol    <= r_v1 & w_eol;
      r_eof    <= r_v1 & w_eof;
    end
  end

  assign valid_o = r_valid2;
  assign mag_o   = r_mag;
  assign edge_o  = r_edge;
  assign sof_o   = r_sof;
  assign eol_o   = r_eol;
  assign eof_o   = r_eof;

endmodule

// File: tb/tb_sobel_magnitude.sv
// Randomized bench for sobel_magnitude against a frame-position reference model.
module tb_sobel_magnitude;

  localparam int D = 4;
  localparam int H = 4;

  logic               clk_i = 1'b0;
  logic               rstn_i = 1'b0;
  logic               valid_i = 1'b0;
  logic               ready_o;
  logic signed [15:0] gx_i = '0;
  logic signed [15:0] gy_i = '0;
  logic               clear_i = 1'b0;
  logic        [7:0]  thresh_i = 8'd50;
  logic               valid_o;
  logic               ready_i = 1'b0;
  logic        [7:0]  mag_o;
  logic               edge_o;
  logic               sof_o;
  logic               eol_o;
  logic               eof_o;

  sobel_magnitude #(.WIDTH_P(8), .DEPTH_P(D), .HEIGHT_P(H), .SHIFT_P(2)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .valid_i(valid_i), .ready_o(ready_o),
    .gx_i(gx_i), .gy_i(gy_i), .clear_i(clear_i), .thresh_i(thresh_i),
    .valid_o(valid_o), .ready_i(ready_i), .mag_o(mag_o), .edge_o(edge_o),
    .sof_o(sof_o), .eol_o(eol_o), .eof_o(eof_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] mag;
    logic       edge_f;
    logic       sof;
    logic       eol;
    logic       eof;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   idx      = 0;
  int   cyc      = 0;
  int   edge_cnt = 0;
  int   sat_cnt  = 0;
  bit   held_v   = 0;
  exp_t held;
  bit   lat_wait = 0;
  bit   lat_armed = 0;
  int   lat_cyc  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Expected output for the n-th beat since the last clear/reset, from raster position.
  function automatic exp_t model(input logic signed [15:0] gx, input logic signed [15:0] gy,
                                 input int n);
    int pos, row, col, ax, ay, s;
    bit border;
    exp_t e;
    pos = n % (D*H);
    row = pos / D;
    col = pos % D;
    ax = int'(gx); if (ax < 0) ax = -ax; if (ax > 32767) ax = 32767;
    ay = int'(gy); if (ay < 0) ay = -ay; if (ay > 32767) ay = 32767;
    s = (ax + ay) / 4;
    if (s > 255) s = 255;
    border = (row < 2) || (col < 2);
    if (border) s = 0;
    e.mag    = 8'(s);
    e.edge_f = !border && (s >= int'(thresh_i));
    e.sof    = (pos == 0);
    e.eol    = (col == D-1);
    e.eof    = (pos == D*H-1);
    return e;
  endfunction

  function automatic logic signed [15:0] rg();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return 16'(int'($urandom_range(0, 1600)) - 800);
  endfunction

  // One clock cycle: check outputs at the falling edge, drive inputs, score transfers.
  task automatic cycle(input bit v, input logic signed [15:0] gx, input logic signed [15:0] gy,
                       input bit rdy, input bit clr, output bit acc);
    exp_t e;
    @(negedge clk_i);
    cyc++;
    if (held_v) begin
      chk("hold_valid", valid_o, 1);
      chk("hold_mag", mag_o, held.mag);
      chk("hold_markers", {edge_o, sof_o, eol_o, eof_o},
          {held.edge_f, held.sof, held.eol, held.eof});
    end
    valid_i = v; gx_i = gx; gy_i = gy; ready_i = rdy; clear_i = clr;
    #1;
    chk("ready_o", ready_o, (!valid_o) || rdy);
    if (lat_armed && valid_o) begin
      chk("latency", cyc - lat_cyc, 2);
      lat_armed = 0;
    end
    held_v = 0;
    if (valid_o && rdy) begin
      if (q.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        e = q.pop_front();
        chk("mag_o", mag_o, e.mag);
        chk("edge_o", edge_o, e.edge_f);
        chk("sof_o", sof_o, e.sof);
        chk("eol_o", eol_o, e.eol);
        chk("eof_o", eof_o, e.eof);
        if (edge_o) edge_cnt++;
        if (mag_o == 8'd255) sat_cnt++;
      end
    end else if (valid_o) begin
      held_v = 1;
      held = '{mag: mag_o, edge_f: edge_o, sof: sof_o, eol: eol_o, eof: eof_o};
    end
    acc = v && ready_o;
    if (clr) idx = 0;
    if (acc) begin
      q.push_back(model(gx, gy, idx));
      idx++;
      if (lat_wait) begin lat_cyc = cyc; lat_armed = 1; lat_wait = 0; end
    end
  endtask

  function automatic bit pick_ready(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) return $urandom_range(0, 99) < 70;
    return !((cyc % 10) >= 4 && (cyc % 10) <= 6);
  endfunction

  task automatic feed(input logic signed [15:0] gx, input logic signed [15:0] gy,
                      input int vprob, input int rmode);
    bit acc;
    int tries;
    acc = 0; tries = 0;
    while (!acc && tries < 100) begin
      cycle($urandom_range(0, 99) < vprob, gx, gy, pick_ready(rmode), 1'b0, acc);
      tries++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    bit acc;
    int t;
    t = 0;
    while (q.size() > 0 && t < 60) begin
      cycle(1'b0, '0, '0, 1'b1, 1'b0, acc);
      t++;
    end
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rstn_i = 1'b0; valid_i = 1'b0; clear_i = 1'b0;
    #1;
    chk("rst_valid_o", valid_o, 0);
    chk("rst_mag_o", mag_o, 0);
    chk("rst_flags", {edge_o, sof_o, eol_o, eof_o}, 0);
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1; ready_i = 1'b1;
    q.delete(); idx = 0; held_v = 0; lat_armed = 0;
  endtask

  initial begin
    bit acc;
    #3;
    chk("init_valid_o", valid_o, 0);
    chk("init_mag_o", mag_o, 0);
    chk("init_flags", {edge_o, sof_o, eol_o, eof_o}, 0);
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;

    // 20 continuous beats of a constant gradient: border masking, markers and frame wrap.
    thresh_i = 8'd50; lat_wait = 1; edge_cnt = 0;
    for (int i = 0; i < 20; i++) feed(16'sd100, -16'sd100, 100, 0);
    drain();
    chk("edge_count", edge_cnt, 4);
    chk("latency_seen", lat_armed, 0);

    // Saturation cases placed at raster position (2,2) and (2,3).
    cycle(1'b0, '0, '0, 1'b1, 1'b1, acc);
    for (int i = 0; i < 10; i++) feed(16'sd0, 16'sd0, 100, 0);
    sat_cnt = 0;
    feed(16'sd1020, -16'sd1020, 100, 0);
    feed(-16'sd32768, 16'sd0, 100, 0);
    drain();
    chk("sat_count", sat_cnt, 2);

    // Stalls: periodic 3-cycle ready_i low on a full stream, then random valid/ready.
    thresh_i = 8'($urandom_range(0, 255));
    for (int i = 0; i < 30; i++) feed(rg(), rg(), 100, 2);
    for (int i = 0; i < 30; i++) feed(rg(), rg(), 70, 1);
    drain();

    // clear_i together with the accept of beat 6.
    thresh_i = 8'd50;
    for (int i = 0; i < 6; i++) feed(rg(), rg(), 100, 0);
    cycle(1'b1, rg(), rg(), 1'b1, 1'b1, acc);
    chk("clear_accept", acc, 1);
    for (int i = 0; i < 8; i++) feed(rg(), rg(), 100, 0);
    drain();

    // Reset while beats are in flight, then restart from the origin.
    for (int i = 0; i < 6; i++) feed(rg(), rg(), 100, 0);
    @(negedge clk_i);
    valid_i = 1'b0;
    chk("pre_reset_valid", valid_o, 1);
    do_reset();
    for (int i = 0; i < 20; i++) feed(rg(), rg(), 80, 1);
    drain();
    chk("queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
